fp_minmax_pipe: RTL and testbench
=================================

Name: fp_minmax_pipe

Overview:
- Parametrised, pipelined IEEE-754 floating-point min/max unit with a valid/ready handshake.
- Successor to the single-register min block. Adds:
  - a per-operation min/max select,
  - a configurable pipeline depth,
  - full backpressure,
  - a sideband tag,
  - a registered status field aligned with the result.
- Sits in the FP execute cluster between the operand issue stage and the writeback arbiter.

Parameters:
- SIGN_W, 1, sign field width (fixed at 1).
- EXPO_W, 8, exponent field width (≥2).
- MANT_W, 23, mantissa field width, hidden bit excluded (≥2).
- LAT, 2, pipeline depth in cycles from input acceptance to out_valid (1..4).
- TAG_W, 4, width of the opaque sideband tag carried with each operation (≥1).

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  unit can accept an operation this cycle
- a  input  SIGN_W+EXPO_W+MANT_W  operand A
- b  input  SIGN_W+EXPO_W+MANT_W  operand B
- op_max  input  1  0 = minimum, 1 = maximum
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- res  output  SIGN_W+EXPO_W+MANT_W  selected/canonical result
- status  output  5  flags {NV,DZ,OF,UF,NX}, bit 4 = NV
- out_tag  output  TAG_W  tag of the operation in res

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-high.
- Reset values, while rst is high and on the cycle after release:
  - all stage valid bits = 0, so out_valid = 0;
  - res = 0, status = 0, out_tag = 0;
  - in_ready = 1.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Pipeline advance signal: adv = !(out_valid && !out_ready).
  - in_ready = adv. This is a combinational path from out_ready, which is permitted.
- Pipeline:
  - LAT stage registers, each holding valid, a, b, op_max, tag and partial results.
  - When adv = 1, every stage loads from its predecessor; stage 0 loads {in_valid, inputs}.
  - When adv = 0, all stages hold their contents; no bubble compaction is done.
  - Throughput is one operation per cycle when out_ready stays high.
  - Latency is exactly LAT cycles from input transfer to out_valid with no stall.
  - Outputs are driven from the final stage register only.
  - While out_valid && !out_ready, res, status and out_tag are stable.
- Classification, computed in stage 0 and registered:
  - NaN: expo all ones and mant ≠ 0.
  - sNaN: NaN with mant MSB = 0.
- Comparison: total order on non-NaN values, with −0 strictly less than +0.
  - Implementation: magnitude compare of {expo, mant}, combined with the signs.
  - min selects the smaller value, max selects the larger.
  - Equal values, including equal infinities, return a.
- NaN rules (IEEE 754-2019 minimumNumber/maximumNumber):
  - Exactly one operand NaN: return the other operand.
  - Both operands NaN: return canonical qNaN = sign 0, expo all ones, mant MSB 1, rest 0.
- Status:
  - NV = 1 if either operand is an sNaN, regardless of the result.
  - DZ, OF, UF and NX are always 0.
- Stage partitioning for LAT > 1:
  - Classify and compare in stage 0; the remaining stages are pure delay.
  - The result is identical for every LAT value.
- Reset mid-operation:
  - All in-flight operations are discarded; no output transfer occurs for them.
  - On release the unit accepts on the first cycle.
- Simultaneous input and output transfer when the pipeline is full is allowed, with no loss of data.
- Inputs must be ignored (don't-care) when in_valid = 0.
  - Bubbles propagate with valid = 0.
  - Payload registers of invalid stages may retain stale values.

Test Plan:
1. LAT=2, fp32, out_ready=1: a=0x3F800000 (1.0), b=0x40000000 (2.0), op_max=0, tag=5.
   - Expect out_valid exactly 2 cycles after acceptance, res=0x3F800000, status=0, out_tag=5.
   - Same operands with op_max=1 → res=0x40000000.
2. Signed zeros: a=0x00000000, b=0x80000000.
   - min → 0x80000000; max → 0x00000000.
   - Equal values a=b=0x7F800000 (+inf) → res=0x7F800000.
3. NaN handling:
   - a=0x7FC00000 (qNaN), b=0xC0400000 (−3.0), min → res=0xC0400000, status=0.
   - a=0x7F800001 (sNaN), b=0x3F800000 → res=0x3F800000, status=0x10.
   - Both inputs qNaN with payloads 0xFFC12345 and 0x7FC00001 → res=0x7FC00000.
4. Backpressure:
   - Stream 6 back-to-back ops with tags 0..5; hold out_ready=0 for cycles 3..6.
   - Expect in_ready=0 while out_valid && !out_ready, outputs stable, and all six results in order with tags 0..5, no duplicates.
5. Reset mid-stream:
   - Assert rst asynchronously (between clock edges) with 2 ops in flight.
   - Expect out_valid drop to 0 immediately and in_ready=1; neither pre-reset op ever appears.
   - A new op after release emerges after LAT cycles.
6. Parameter sweep: LAT∈{1,4}, fp16 (EXPO_W=5, MANT_W=10).
   - a=0x3C00 (1.0), b=0xBC00 (−1.0), max → res=0x3C00 at latency LAT.
   - Random stimulus compared against a reference model, 10k ops with random stalls.

Source files
------------

// File: rtl/fp_minmax_pipe.sv
// rtl/fp_minmax_pipe.sv - pipelined IEEE-754 minimumNumber/maximumNumber unit with valid/ready handshake
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready follows the pipeline advance signal
//   a, b, op_max        operands and select (0 = min, 1 = max)
//   in_tag / out_tag    opaque sideband tag carried alongside each operation
//   out_valid/out_ready output handshake
//   res, status         selected/canonical result and flags {NV,DZ,OF,UF,NX}
module fp_minmax_pipe #(
   parameter int SIGN_W = 1,
   parameter int EXPO_W = 8,
   parameter int MANT_W = 23,
   parameter int LAT    = 2,
   parameter int TAG_W  = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [SIGN_W+EXPO_W+MANT_W-1:0] a,
   input  logic [SIGN_W+EXPO_W+MANT_W-1:0] b,
   input  logic                            op_max,
   input  logic [TAG_W-1:0]                in_tag,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [SIGN_W+EXPO_W+MANT_W-1:0] res,
   output logic [4:0]                      status,
   output logic [TAG_W-1:0]                out_tag
);

   localparam int W   = SIGN_W + EXPO_W + MANT_W;
   localparam int MAG = EXPO_W + MANT_W;
   localparam logic [W-1:0] QNAN = {{SIGN_W{1'b0}}, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

   // Stage-0 classification, ordering and selection
   logic           a_sign, b_sign;
   logic [MAG-1:0] a_mag, b_mag;
   logic           a_nan, b_nan, a_snan, b_snan;
   logic           a_lt_b, b_lt_a, pick_b;
   logic [W-1:0]   s0_res;
   logic [4:0]     s0_status;

   always_comb begin
      a_sign = a[W-1];
      b_sign = b[W-1];
      a_mag  = a[MAG-1:0];
      b_mag  = b[MAG-1:0];
      a_nan  = (&a[MAG-1:MANT_W]) && (|a[MANT_W-1:0]);
      b_nan  = (&b[MAG-1:MANT_W]) && (|b[MANT_W-1:0]);
      a_snan = a_nan && !a[MANT_W-1];
      b_snan = b_nan && !b[MANT_W-1];

      // Differing signs: the negative operand is smaller, which also orders -0 below +0.
      // Same sign: magnitude order, reversed when both are negative.
      if (a_sign != b_sign) begin
         a_lt_b = a_sign;
         b_lt_a = b_sign;
      end else if (!a_sign) begin
         a_lt_b = a_mag < b_mag;
         b_lt_a = b_mag < a_mag;
      end else begin
         a_lt_b = a_mag > b_mag;
         b_lt_a = b_mag > a_mag;
      end

      // b is chosen only when strictly better, so ties (including equal infinities) return a
      pick_b = op_max ? a_lt_b : b_lt_a;

      if (a_nan && b_nan) begin
         s0_res = QNAN;
      end else if (a_nan) begin
         s0_res = b;
      end else if (b_nan) begin
         s0_res = a;
      end else begin
         s0_res = pick_b ? b : a;
      end

      s0_status = {a_snan || b_snan, 4'b0000};
   end

   // Pipeline: stage 0 captures the computed result, later stages are pure delay
   logic [LAT-1:0] valid_q, valid_d;
   logic [W-1:0]   res_q    [LAT];
   logic [W-1:0]   res_d    [LAT];
   logic [4:0]     status_q [LAT];
   logic [4:0]     status_d [LAT];
   logic [TAG_W-1:0] tag_q  [LAT];
   logic [TAG_W-1:0] tag_d  [LAT];
   logic           adv;

   assign out_valid = valid_q[LAT-1];
   assign res       = res_q[LAT-1];
   assign status    = status_q[LAT-1];
   assign out_tag   = tag_q[LAT-1];
   // Whole pipe freezes only when the final stage holds a result the consumer refuses
   assign adv       = !(out_valid && !out_ready);
   assign in_ready  = adv;

   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < LAT; i++) begin
         res_d[i]    = res_q[i];
         status_d[i] = status_q[i];
         tag_d[i]    = tag_q[i];
      end
      if (adv) begin
         valid_d[0]  = in_valid;
         res_d[0]    = s0_res;
         status_d[0] = s0_status;
         tag_d[0]    = in_tag;
         for (int i = 1; i < LAT; i++) begin
            valid_d[i]  = valid_q[i-1];
            res_d[i]    = res_q[i-1];
            status_d[i] = status_q[i-1];
            tag_d[i]    = tag_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            res_q[i]    <= '0;
            status_q[i] <= '0;
            tag_q[i]    <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < LAT; i++) begin
            res_q[i]    <= res_d[i];
            status_q[i] <= status_d[i];
            tag_q[i]    <= tag_d[i];
         end
      end
   end

endmodule

// File: tb/tb_fp_minmax_pipe.sv
// tb/tb_fp_minmax_pipe.sv - directed and randomised checks of fp_minmax_pipe (fp32 LAT=2, fp16 LAT=1 and LAT=4)
module tb_fp_minmax_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // fp32, LAT=2
   logic        iv0 = 1'b0, ir0, op0 = 1'b0, ov0, ovr0 = 1'b1;
   logic [31:0] a0 = '0, b0 = '0, res0;
   logic [3:0]  tag0 = '0, ot0;
   logic [4:0]  st0;
   // fp16, LAT=1
   logic        iv1 = 1'b0, ir1, op1 = 1'b0, ov1, ovr1 = 1'b1;
   logic [15:0] a1 = '0, b1 = '0, res1;
   logic [3:0]  tag1 = '0, ot1;
   logic [4:0]  st1;
   // fp16, LAT=4
   logic        iv4 = 1'b0, ir4, op4 = 1'b0, ov4, ovr4 = 1'b1;
   logic [15:0] a4 = '0, b4 = '0, res4;
   logic [7:0]  tag4 = '0, ot4;
   logic [4:0]  st4;

   fp_minmax_pipe #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23), .LAT(2), .TAG_W(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .op_max(op0),
      .in_tag(tag0), .out_valid(ov0), .out_ready(ovr0), .res(res0), .status(st0), .out_tag(ot0));

   fp_minmax_pipe #(.SIGN_W(1), .EXPO_W(5), .MANT_W(10), .LAT(1), .TAG_W(4)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .op_max(op1),
      .in_tag(tag1), .out_valid(ov1), .out_ready(ovr1), .res(res1), .status(st1), .out_tag(ot1));

   fp_minmax_pipe #(.SIGN_W(1), .EXPO_W(5), .MANT_W(10), .LAT(4), .TAG_W(8)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .op_max(op4),
      .in_tag(tag4), .out_valid(ov4), .out_ready(ovr4), .res(res4), .status(st4), .out_tag(ot4));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One fp32 op through an otherwise idle LAT=2 pipe, checking exact latency
   task automatic run32(input string name, input logic [31:0] va, input logic [31:0] vb,
                        input logic vop, input logic [3:0] vtag,
                        input logic [31:0] eres, input logic [4:0] est);
      a0 = va; b0 = vb; op0 = vop; tag0 = vtag; iv0 = 1'b1;
      #1;
      check({name, "_in_ready"}, 32'(ir0), 32'd1);
      step();
      iv0 = 1'b0;
      check({name, "_early"}, 32'(ov0), 32'd0);
      step();
      check({name, "_valid"}, 32'(ov0), 32'd1);
      check({name, "_res"}, res0, eres);
      check({name, "_status"}, 32'(st0), 32'(est));
      check({name, "_tag"}, 32'(ot0), 32'(vtag));
      step();
   endtask

   // Reference built on a monotone integer key: +x -> x|msb, -x -> ~x
   function automatic logic [15:0] key16(input logic [15:0] x);
      return x[15] ? ~x : (x | 16'h8000);
   endfunction

   function automatic logic [20:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic mx);
      logic xn, yn, xs, ys;
      logic [15:0] r;
      xn = (x[14:10] == 5'h1F) && (x[9:0] != 10'h0);
      yn = (y[14:10] == 5'h1F) && (y[9:0] != 10'h0);
      xs = xn && !x[9];
      ys = yn && !y[9];
      if (xn && yn)      r = 16'h7E00;
      else if (xn)       r = y;
      else if (yn)       r = x;
      else if (mx)       r = (key16(y) > key16(x)) ? y : x;
      else               r = (key16(y) < key16(x)) ? y : x;
      return {xs || ys, 4'b0000, r};
   endfunction

   function automatic logic [15:0] rnd16();
      case ($urandom_range(7))
         0: return 16'h0000;
         1: return 16'h8000;
         2: return ($urandom_range(1) != 0) ? 16'h7C00 : 16'hFC00;
         3: return ($urandom_range(1) != 0) ? 16'h7E00 : 16'hFE55;
         4: return ($urandom_range(1) != 0) ? 16'h7C01 : 16'hFD55;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      int sent, got, accepted;
      logic [28:0] q[$];
      logic [28:0] e;

      // Reset state while rst is high, then on the cycle after release
      #2;
      check("rst_out_valid", 32'(ov0), 32'd0);
      check("rst_res", res0, 32'd0);
      check("rst_status", 32'(st0), 32'd0);
      check("rst_out_tag", 32'(ot0), 32'd0);
      check("rst_in_ready", 32'(ir0), 32'd1);
      step();
      step();
      rst = 1'b0;
      step();
      check("rel_out_valid", 32'(ov0), 32'd0);
      check("rel_in_ready", 32'(ir0), 32'd1);
      check("rel_res", res0, 32'd0);

      // Basic min/max, signed zeros, equal infinities, NaN rules
      run32("min_1_2", 32'h3F800000, 32'h40000000, 1'b0, 4'd5, 32'h3F800000, 5'h00);
      run32("max_1_2", 32'h3F800000, 32'h40000000, 1'b1, 4'd6, 32'h40000000, 5'h00);
      run32("min_zero", 32'h00000000, 32'h80000000, 1'b0, 4'd1, 32'h80000000, 5'h00);
      run32("max_zero", 32'h00000000, 32'h80000000, 1'b1, 4'd2, 32'h00000000, 5'h00);
      run32("eq_inf", 32'h7F800000, 32'h7F800000, 1'b0, 4'd3, 32'h7F800000, 5'h00);
      run32("qnan_a", 32'h7FC00000, 32'hC0400000, 1'b0, 4'd4, 32'hC0400000, 5'h00);
      run32("snan_a", 32'h7F800001, 32'h3F800000, 1'b0, 4'd7, 32'h3F800000, 5'h10);
      run32("qnan_both", 32'hFFC12345, 32'h7FC00001, 1'b1, 4'd8, 32'h7FC00000, 5'h00);
      run32("snan_b_max", 32'hBF800000, 32'hFF800005, 1'b1, 4'd9, 32'hBF800000, 5'h10);
      run32("neg_min", 32'hC0000000, 32'hBF800000, 1'b0, 4'd10, 32'hC0000000, 5'h00);

      // Backpressure: six back-to-back ops (max(a_i, 2.0)), consumer stalls cycles 3..6
      sent = 0;
      got = 0;
      for (int c = 0; c < 14; c++) begin
         ovr0 = !(c >= 3 && c <= 6);
         if (sent < 6) begin
            iv0 = 1'b1;
            a0 = {1'b0, 8'(127 + sent), 23'h0};
            b0 = 32'h40000000;
            op0 = 1'b1;
            tag0 = 4'(sent);
         end else begin
            iv0 = 1'b0;
         end
         #1;
         check("bp_in_ready", 32'(ir0), 32'(!(c >= 3 && c <= 6)));
         if (c >= 3 && c <= 6) begin
            check("bp_hold_valid", 32'(ov0), 32'd1);
            check("bp_hold_tag", 32'(ot0), 32'd1);
            check("bp_hold_res", res0, 32'h40000000);
         end
         if (ov0 && ovr0) begin
            check("bp_tag", 32'(ot0), 32'(got));
            check("bp_res", res0, (got == 0) ? 32'h40000000 : {1'b0, 8'(127 + got), 23'h0});
            got++;
         end
         if (iv0 && ir0) sent++;
         step();
      end
      check("bp_count", 32'(got), 32'd6);
      check("bp_sent", 32'(sent), 32'd6);

      // Reset with two ops in flight and the consumer stalled
      ovr0 = 1'b0;
      a0 = 32'h3F800000; b0 = 32'h40000000; op0 = 1'b0; tag0 = 4'd12; iv0 = 1'b1;
      step();
      tag0 = 4'd13;
      step();
      iv0 = 1'b0;
      check("pre_rst_valid", 32'(ov0), 32'd1);
      check("pre_rst_in_ready", 32'(ir0), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(ov0), 32'd0);
      check("mid_rst_in_ready", 32'(ir0), 32'd1);
      check("mid_rst_tag", 32'(ot0), 32'd0);
      step();
      #2;
      rst = 1'b0;
      ovr0 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check("post_rst_no_ghost", 32'(ov0), 32'd0);
         step();
      end
      run32("post_rst", 32'h40400000, 32'hC0400000, 1'b1, 4'd14, 32'h40400000, 5'h00);

      // fp16 LAT=1 and LAT=4: max(1.0, -1.0) at exact latency
      a1 = 16'h3C00; b1 = 16'hBC00; op1 = 1'b1; tag1 = 4'd3; iv1 = 1'b1;
      a4 = 16'h3C00; b4 = 16'hBC00; op4 = 1'b1; tag4 = 8'd33; iv4 = 1'b1;
      step();
      iv1 = 1'b0;
      iv4 = 1'b0;
      check("l1_valid", 32'(ov1), 32'd1);
      check("l1_res", 32'(res1), 32'h3C00);
      check("l1_tag", 32'(ot1), 32'd3);
      check("l4_early1", 32'(ov4), 32'd0);
      step();
      check("l1_drained", 32'(ov1), 32'd0);
      check("l4_early2", 32'(ov4), 32'd0);
      step();
      check("l4_early3", 32'(ov4), 32'd0);
      step();
      check("l4_valid", 32'(ov4), 32'd1);
      check("l4_res", 32'(res4), 32'h3C00);
      check("l4_tag", 32'(ot4), 32'd33);
      step();

      // LAT=4 fp16: random operands and handshakes against the key-based reference
      accepted = 0;
      for (int cyc = 0; cyc < 40000 && (accepted < 10000 || q.size() > 0); cyc++) begin
         iv4 = (accepted < 10000) && ($urandom_range(3) != 0);
         a4 = rnd16();
         b4 = ($urandom_range(7) == 0) ? a4 : rnd16();
         op4 = 1'($urandom_range(1));
         tag4 = 8'(accepted);
         ovr4 = ($urandom_range(3) != 0);
         @(negedge clk);
         if (ov4 && ovr4) begin
            if (q.size() == 0) begin
               check("rnd_spurious", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("rnd_tag", 32'(ot4), 32'(e[28:21]));
               check("rnd_status", 32'(st4), 32'(e[20:16]));
               check("rnd_res", 32'(res4), 32'(e[15:0]));
            end
         end
         if (iv4 && ir4) begin
            q.push_back({tag4, ref16(a4, b4, op4)});
            accepted++;
         end
         step();
      end
      iv4 = 1'b0;
      check("rnd_accepted", 32'(accepted), 32'd10000);
      check("rnd_drained", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
